bcd_scan_display: RTL and testbench



---
 rtl/bcd_display_pkg.sv | 45 ++++
 rtl/bcd_serial.sv | 118 +++++++++++
 rtl/bcd_scan_display.sv | 110 +++++++++++
 tb/tb_bcd_scan_display.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants, helpers and converter state encoding for the scanned BCD display.
// Segment bit order is [0]=a ... [6]=g, active-high before any polarity inversion.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } conv_state_t;

    // Decimal digits of 2^width-1, i.e. floor(width*log10(2))+1; 2^width is never a power of ten.
    function automatic int bcd_nibbles(input int width);
        return ((width * 30103) / 100000) + 1;
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_serial.sv
// Sequential double-dabble converter: WIDTH shift cycles, then a commit cycle.
// bcd and done are registered on the edge that finishes the last shift.
module bcd_serial
    import bcd_display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  hwclk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    conv_state_t          state_r;
    conv_state_t          state_nxt_s;
    logic [BW-1:0]        scratch_r;
    logic [WIDTH-1:0]     shift_r;
    logic [CW-1:0]        count_r;
    logic [BW-1:0]        adjusted_s;
    logic [BW+WIDTH-1:0]  shifted_s;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    assign adjusted_s = add3(scratch_r);
    assign shifted_s  = {adjusted_s, shift_r} << 1;

    // Converter state register.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r <= CONV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a load outside IDLE is simply dropped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CONV_IDLE: begin
                if (load) begin
                    state_nxt_s = CONV_SHIFT;
                end else begin
                    state_nxt_s = CONV_IDLE;
                end
            end
            CONV_SHIFT: begin
                if (count_r == LAST_ITER) begin
                    state_nxt_s = CONV_COMMIT;
                end else begin
                    state_nxt_s = CONV_SHIFT;
                end
            end
            CONV_COMMIT: state_nxt_s = CONV_IDLE;
            default:     state_nxt_s = CONV_IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            scratch_r <= '0;
            shift_r   <= '0;
            count_r   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                CONV_IDLE: begin
                    if (load) begin
                        shift_r   <= value;
                        scratch_r <= '0;
                        count_r   <= '0;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CONV_SHIFT: begin
                    scratch_r <= shifted_s[BW+WIDTH-1 -: BW];
                    shift_r   <= shifted_s[WIDTH-1:0];
                    count_r   <= count_r + 1'b1;
                    if (count_r == LAST_ITER) begin
                        bcd  <= shifted_s[BW+WIDTH-1 -: BW];
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                CONV_COMMIT: busy <= 1'b0;
                default:     busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Binary-to-BCD conversion feeding a multiplexed 7-segment display with
// programmable scan rate, leading-zero blanking and a dark guard cycle per slot.
module bcd_scan_display
    import bcd_display_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter int SCAN_DIV       = 600,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int EN_ACTIVE_LOW  = 0
) (
    input  logic                  hwclk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     enable
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0]  TICK     = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] EN_OFF   = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    if (WIDTH < 1) begin : g_bad_width
        $error("bcd_scan_display: WIDTH must be at least 1");
    end
    if (DIGITS < bcd_nibbles(WIDTH)) begin : g_bad_digits
        $error("bcd_scan_display: DIGITS too small for WIDTH");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("bcd_scan_display: SCAN_DIV must be at least 2");
    end

    logic [DIV_W-1:0]  div_r;
    logic [IDX_W-1:0]  index_r;
    logic [DIGITS-1:0] zero_above_s;
    logic [3:0]        digit_s;
    logic              blank_s;
    logic [DIGITS-1:0] onehot_s;

    bcd_serial #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .hwclk (hwclk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // zero_above_s[i]: digits i..DIGITS-1 of the committed value are all zero.
    always_comb begin
        logic run;
        run          = 1'b1;
        zero_above_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run             = run && (bcd[4*i +: 4] == 4'd0);
            zero_above_s[i] = run;
        end
    end

    assign digit_s  = bcd[index_r*4 +: 4];
    assign blank_s  = (BLANK_LZ != 0) && (index_r != '0) && zero_above_s[index_r];
    assign onehot_s = DIGITS'(1'b1) << index_r;

    // Scan divider, slot index and registered display outputs.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            div_r    <= '0;
            index_r  <= LAST_IDX;
            enable   <= EN_OFF;
            segments <= SEG_OFF;
            dp       <= DP_OFF;
        end else begin
            dp <= DP_OFF;
            if (div_r == TICK) begin
                div_r    <= '0;
                enable   <= EN_OFF;
                segments <= SEG_OFF;
                if (index_r == '0) begin
                    index_r <= LAST_IDX;
                end else begin
                    index_r <= index_r - 1'b1;
                end
            end else begin
                div_r <= div_r + 1'b1;
                if (blank_s) begin
                    enable   <= EN_OFF;
                    segments <= SEG_OFF;
                end else begin
                    enable   <= onehot_s ^ EN_OFF;
                    segments <= seg_pattern(digit_s) ^ SEG_OFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboarded bench: three configurations of bcd_scan_display driven with directed values.
`timescale 1ns/1ps
module tb_bcd_scan_display;

    typedef struct {
        logic [19:0] bcd;
        int          cyc;
    } exp_t;

    logic        hwclk = 1'b0;
    logic        rst   = 1'b1;
    logic [7:0]  value_a = 8'd0;
    logic        load_a  = 1'b0;
    logic [15:0] value_c = 16'd0;
    logic        load_c  = 1'b0;

    logic        busy_a, done_a, dp_a, busy_b, done_b, dp_b, busy_c, done_c, dp_c;
    logic [11:0] bcd_a, bcd_b;
    logic [19:0] bcd_c;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic [2:0]  en_a, en_b;
    logic [4:0]  en_c;

    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qc[$];

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) cyc <= cyc + 1;

    bcd_scan_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1),
                       .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)) dut_a (
        .hwclk(hwclk), .rst(rst), .value(value_a), .load(load_a), .busy(busy_a),
        .done(done_a), .bcd(bcd_a), .segments(seg_a), .dp(dp_a), .enable(en_a));

    bcd_scan_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(0),
                       .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)) dut_b (
        .hwclk(hwclk), .rst(rst), .value(value_a), .load(load_a), .busy(busy_b),
        .done(done_b), .bcd(bcd_b), .segments(seg_b), .dp(dp_b), .enable(en_b));

    bcd_scan_display #(.WIDTH(16), .DIGITS(5), .SCAN_DIV(4), .BLANK_LZ(1),
                       .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(0)) dut_c (
        .hwclk(hwclk), .rst(rst), .value(value_c), .load(load_c), .busy(busy_c),
        .done(done_c), .bcd(bcd_c), .segments(seg_c), .dp(dp_c), .enable(en_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge hwclk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            if (qa.size() == 0) begin
                check("unexpected done A", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("bcd A", 32'(bcd_a), 32'(e.bcd));
                check("latency A", 32'(cyc), 32'(e.cyc));
            end
        end
        if (done_c === 1'b1) begin
            if (qc.size() == 0) begin
                check("unexpected done C", 32'd1, 32'd0);
            end else begin
                e = qc.pop_front();
                check("bcd C", 32'(bcd_c), 32'(e.bcd));
                check("latency C", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_load_a(input logic [7:0] v, input logic [11:0] e, input bit push);
        @(negedge hwclk);
        value_a = v;
        load_a  = 1'b1;
        if (push) qa.push_back('{bcd: 20'(e), cyc: cyc + 9});
        @(negedge hwclk);
        load_a = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (qa.size() != 0 || qc.size() != 0); i++) @(negedge hwclk);
        @(negedge hwclk);
        check("scoreboard drained", 32'(qa.size() + qc.size()), 32'd0);
    endtask

    // One full frame (12 cycles) of dut A or B; phase-independent counts per enable code.
    task automatic check_frame(input string name, input bit use_b,
                               input logic [2:0] exp_lit, input logic [2:0][6:0] exp_seg);
        int lit[3];
        int dark, bad_seg, bad_en, nlit;
        logic [2:0] en;
        logic [6:0] sg;
        lit = '{0, 0, 0};
        dark = 0; bad_seg = 0; bad_en = 0; nlit = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge hwclk);
            en = use_b ? en_b : en_a;
            sg = use_b ? seg_b : seg_a;
            case (en)
                3'b000: dark++;
                3'b001: begin lit[0]++; if (sg !== exp_seg[0]) bad_seg++; end
                3'b010: begin lit[1]++; if (sg !== exp_seg[1]) bad_seg++; end
                3'b100: begin lit[2]++; if (sg !== exp_seg[2]) bad_seg++; end
                default: bad_en++;
            endcase
        end
        for (int i = 0; i < 3; i++) begin
            if (exp_lit[i]) nlit++;
            check($sformatf("%s lit cycles digit %0d", name, i), 32'(lit[i]), exp_lit[i] ? 32'd3 : 32'd0);
        end
        check({name, " dark cycles"}, 32'(dark), 32'(12 - 3 * nlit));
        check({name, " segment errors"}, 32'(bad_seg), 32'd0);
        check({name, " non-onehot enables"}, 32'(bad_en), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int units, tens;
        repeat (3) @(negedge hwclk);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset done", 32'(done_a), 32'd0);
        check("reset bcd", 32'(bcd_a), 32'd0);
        check("reset enable", 32'(en_a), 32'd0);
        check("reset segments", 32'(seg_a), 32'd0);
        check("reset dp", 32'(dp_a), 32'd0);
        check("reset segments C inverted", 32'(seg_c), 32'h7F);
        check("reset dp C inverted", 32'(dp_c), 32'd1);
        rst = 1'b0;
        @(negedge hwclk);
        check("first slot B enable", 32'(en_b), 32'b100);
        check("first slot B segments", 32'(seg_b), 32'h3F);
        check("first slot A blanked", 32'(en_a), 32'b000);

        // 255: latency and busy window (busy on cycles 1..8 after the load)
        do_load_a(8'd255, 12'h255, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge hwclk);
            check($sformatf("busy cycle %0d", k), 32'(busy_a), (k <= 8) ? 32'd1 : 32'd0);
        end
        wait_idle();

        do_load_a(8'd7, 12'h007, 1'b1);
        wait_idle();
        repeat (2) @(negedge hwclk);
        check_frame("A val7", 1'b0, 3'b001, {7'h3F, 7'h3F, 7'h07});
        check_frame("B val7", 1'b1, 3'b111, {7'h3F, 7'h3F, 7'h07});

        do_load_a(8'd0, 12'h000, 1'b1);
        wait_idle();
        repeat (2) @(negedge hwclk);
        check_frame("A val0", 1'b0, 3'b001, {7'h3F, 7'h3F, 7'h3F});
        check_frame("B val0", 1'b1, 3'b111, {7'h3F, 7'h3F, 7'h3F});

        do_load_a(8'd100, 12'h100, 1'b1);
        wait_idle();
        repeat (2) @(negedge hwclk);
        check_frame("A val100", 1'b0, 3'b111, {7'h06, 7'h3F, 7'h3F});

        // 200 then 9 while busy: only the first conversion may complete
        do_load_a(8'd200, 12'h200, 1'b1);
        @(negedge hwclk);
        value_a = 8'd9;
        load_a  = 1'b1;
        @(negedge hwclk);
        load_a = 1'b0;
        wait_idle();
        repeat (15) @(negedge hwclk);
        check("bcd after ignored load", 32'(bcd_a), 32'h200);

        // reset on cycle 4 of a conversion of 255
        do_load_a(8'd255, 12'h255, 1'b0);
        repeat (3) @(negedge hwclk);
        rst = 1'b1;
        @(negedge hwclk);
        rst = 1'b0;
        check("bcd after mid reset", 32'(bcd_a), 32'd0);
        check("busy after mid reset", 32'(busy_a), 32'd0);
        repeat (15) @(negedge hwclk);
        do_load_a(8'd42, 12'h042, 1'b1);
        wait_idle();

        // load coincident with reset is dropped
        @(negedge hwclk);
        rst = 1'b1;
        value_a = 8'd99;
        load_a  = 1'b1;
        @(negedge hwclk);
        rst = 1'b0;
        load_a = 1'b0;
        check("busy after load during reset", 32'(busy_a), 32'd0);
        repeat (12) @(negedge hwclk);
        check("bcd after load during reset", 32'(bcd_a), 32'd0);

        // 16-bit, five digits, inverted segments
        @(negedge hwclk);
        value_c = 16'd65535;
        load_c  = 1'b1;
        qc.push_back('{bcd: 20'h65535, cyc: cyc + 17});
        @(negedge hwclk);
        load_c = 1'b0;
        wait_idle();
        repeat (2) @(negedge hwclk);
        units = 0;
        tens  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge hwclk);
            if (en_c == 5'b00001 && seg_c == 7'b0010010) units++;
            if (en_c == 5'b00010 && seg_c == 7'b0110000) tens++;
        end
        check("C units 5 inverted", 32'(units), 32'd3);
        check("C tens 3 inverted", 32'(tens), 32'd3);
        check("C dp inactive", 32'(dp_c), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
